// File: rtl/coherent_count_reader.sv
// Coherent LOW/HIGH word reader for a free-running 32-bit counter.
// A LOW read freezes a snapshot until the matching HIGH read, a write, or a timeout.
module coherent_count_reader #(
    parameter logic [7:0]  ADDR_LOW       = 8'h10,
    parameter logic [7:0]  ADDR_HIGH      = 8'h11,
    parameter logic [7:0]  ADDR_STATUS    = 8'h12,
    parameter logic [7:0]  ADDR_CLEAR     = 8'h13,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic        xclk,
    input  logic        reset,
    input  logic        write_qualified,
    input  logic        read_qualified,
    input  logic [7:0]  ab,
    input  logic [31:0] count_in,
    output logic [15:0] db_out_CR,
    output logic        data_from_CR_avail,
    output logic        hold_active
);

    typedef enum logic [0:0] {StIdle, StHeld} state_e;

    state_e      state_q, state_d;
    logic [31:0] snapshot_q, snapshot_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  abandon_q, abandon_d;
    logic [15:0] db_q, db_d;
    logic        avail_q, avail_d;
    logic [7:0]  read_ab_q, read_ab_d;
    logic        hold_q;
    logic        read_qualified_d1;
    logic        write_qualified_d1;

    logic read_ev, write_ev;
    logic rd_low, rd_high, rd_status;
    logic clear_ev;
    logic hold_abort;

    // One action per strobe assertion, regardless of strobe length
    assign read_ev  = read_qualified & ~read_qualified_d1;
    assign write_ev = write_qualified & ~write_qualified_d1;

    assign rd_low    = read_ev & (ab == ADDR_LOW);
    assign rd_high   = read_ev & (ab == ADDR_HIGH);
    assign rd_status = read_ev & (ab == ADDR_STATUS);
    assign clear_ev  = write_ev & (ab == ADDR_CLEAR);

    always_comb begin
        state_d    = state_q;
        snapshot_d = snapshot_q;
        timer_d    = timer_q;
        hold_abort = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rd_low) begin
                    state_d = StHeld;
                    timer_d = TIMEOUT_CYCLES;
                end else begin
                    snapshot_d = count_in;
                end
            end
            StHeld: begin
                if (timer_q > 16'd1) begin
                    timer_d = timer_q - 16'd1;
                end
                // HIGH read beats write abort, which beats timeout; a LOW read only reloads
                if (rd_high) begin
                    state_d = StIdle;
                end else if (write_ev) begin
                    state_d    = StIdle;
                    hold_abort = 1'b1;
                end else if (timer_q == 16'd1) begin
                    state_d    = StIdle;
                    hold_abort = 1'b1;
                end else if (rd_low) begin
                    timer_d = TIMEOUT_CYCLES;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Clear wins over a simultaneous abandon increment
    always_comb begin
        abandon_d = abandon_q;
        if (clear_ev) begin
            abandon_d = 8'h00;
        end else if (hold_abort && (abandon_q != 8'hFF)) begin
            abandon_d = abandon_q + 8'd1;
        end
    end

    always_comb begin
        db_d      = db_q;
        read_ab_d = read_ab_q;
        avail_d   = avail_q & read_qualified & (ab == read_ab_q);
        if (read_ev) begin
            read_ab_d = ab;
            avail_d   = 1'b1;
            if (rd_low) begin
                db_d = snapshot_q[15:0];
            end else if (rd_high) begin
                db_d = snapshot_q[31:16];
            end else if (rd_status) begin
                db_d = {hold_q, 7'b0, abandon_q};
            end else begin
                db_d    = 16'hFFFF;
                avail_d = 1'b0;
            end
        end
    end

    always_ff @(posedge xclk or negedge reset) begin
        if (!reset) begin
            state_q            <= StIdle;
            snapshot_q         <= 32'h0;
            timer_q            <= 16'h0;
            abandon_q          <= 8'h0;
            db_q               <= 16'h0;
            avail_q            <= 1'b0;
            read_ab_q          <= 8'h0;
            hold_q             <= 1'b0;
            read_qualified_d1  <= 1'b0;
            write_qualified_d1 <= 1'b0;
        end else begin
            state_q            <= state_d;
            snapshot_q         <= snapshot_d;
            timer_q            <= timer_d;
            abandon_q          <= abandon_d;
            db_q               <= db_d;
            avail_q            <= avail_d;
            read_ab_q          <= read_ab_d;
            hold_q             <= (state_d == StHeld);
            read_qualified_d1  <= read_qualified;
            write_qualified_d1 <= write_qualified;
        end
    end

    assign db_out_CR          = db_q;
    assign data_from_CR_avail = avail_q;
    assign hold_active        = hold_q;

endmodule

// File: tb/tb_coherent_count_reader.sv
// Randomized and directed bench for coherent_count_reader against a cycle-indexed
// reference model (hold deadlines tracked as absolute edge numbers).
module tb_coherent_count_reader;

    localparam logic [7:0] A_LOW   = 8'h10;
    localparam logic [7:0] A_HIGH  = 8'h11;
    localparam logic [7:0] A_STAT  = 8'h12;
    localparam logic [7:0] A_CLR   = 8'h13;
    localparam int         T       = 64;

    logic        xclk = 1'b0;
    logic        reset = 1'b0;
    logic        wq = 1'b0;
    logic        rq = 1'b0;
    logic [7:0]  ab = 8'h00;
    logic [31:0] count_in = 32'h0;
    logic [15:0] db_out_CR;
    logic        data_from_CR_avail;
    logic        hold_active;

    always #5 xclk = ~xclk;

    coherent_count_reader #(
        .TIMEOUT_CYCLES(16'(T))
    ) dut (
        .xclk              (xclk),
        .reset             (reset),
        .write_qualified   (wq),
        .read_qualified    (rq),
        .ab                (ab),
        .count_in          (count_in),
        .db_out_CR         (db_out_CR),
        .data_from_CR_avail(data_from_CR_avail),
        .hold_active       (hold_active)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic        m_held;
    logic [31:0] m_snap;
    int          m_deadline;
    int          m_abandon;
    logic [15:0] m_db;
    logic        m_avail;
    logic [7:0]  m_avail_ab;
    logic        m_rq_prev, m_wq_prev;
    int          edge_n;
    int          count_step = 1;

    task automatic model_reset();
        m_held = 1'b0; m_snap = 32'h0; m_deadline = -1; m_abandon = 0;
        m_db = 16'h0; m_avail = 1'b0; m_avail_ab = 8'h0;
        m_rq_prev = 1'b0; m_wq_prev = 1'b0;
    endtask

    // Effect of one rising edge with the currently driven inputs
    task automatic model_edge();
        logic rev, wev, enter, abort, nheld;
        rev = rq && !m_rq_prev;
        wev = wq && !m_wq_prev;
        m_rq_prev = rq;
        m_wq_prev = wq;
        edge_n++;
        if (rev) begin
            m_avail_ab = ab;
            m_avail    = 1'b1;
            if (ab == A_LOW)       m_db = m_snap[15:0];
            else if (ab == A_HIGH) m_db = m_snap[31:16];
            else if (ab == A_STAT) m_db = {m_held, 7'b0, 8'(m_abandon)};
            else begin
                m_db    = 16'hFFFF;
                m_avail = 1'b0;
            end
        end else begin
            m_avail = m_avail && rq && (ab == m_avail_ab);
        end
        enter = 1'b0; abort = 1'b0; nheld = m_held;
        if (!m_held) begin
            if (rev && ab == A_LOW) begin
                nheld = 1'b1; enter = 1'b1; m_deadline = edge_n + T;
            end
        end else if (rev && ab == A_HIGH) begin
            nheld = 1'b0;
        end else if (wev) begin
            nheld = 1'b0; abort = 1'b1;
        end else if (edge_n == m_deadline) begin
            nheld = 1'b0; abort = 1'b1;
        end else if (rev && ab == A_LOW) begin
            m_deadline = edge_n + T;
        end
        if (wev && ab == A_CLR) m_abandon = 0;
        else if (abort)         m_abandon = (m_abandon < 255) ? m_abandon + 1 : 255;
        if (!m_held && !enter) m_snap = count_in;
        m_held = nheld;
    endtask

    task automatic cycle(input logic w, input logic r, input logic [7:0] a);
        @(negedge xclk);
        check_eq("db_out_CR", {16'h0, db_out_CR}, {16'h0, m_db});
        check_eq("avail", {31'h0, data_from_CR_avail}, {31'h0, m_avail});
        check_eq("hold_active", {31'h0, hold_active}, {31'h0, m_held});
        wq = w; rq = r; ab = a;
        count_in = count_in + 32'(count_step);
        model_edge();
        @(posedge xclk);
    endtask

    initial begin
        int k;
        int prev_ab;
        logic [7:0] addr_tab [6];
        addr_tab[0] = A_LOW; addr_tab[1] = A_HIGH; addr_tab[2] = A_STAT;
        addr_tab[3] = A_CLR; addr_tab[4] = 8'h05;  addr_tab[5] = 8'h7F;
        edge_n = 0;
        model_reset();
        repeat (3) @(posedge xclk);
        #1;
        check_eq("reset_db", {16'h0, db_out_CR}, 32'h0);
        check_eq("reset_avail", {31'h0, data_from_CR_avail}, 32'h0);
        check_eq("reset_hold", {31'h0, hold_active}, 32'h0);
        #1 reset = 1'b1;

        // Coherent pair across the 0x0001_FFFF -> 0x0002_0000 rollover
        count_in = 32'h0001_FFEF;
        cycle(0, 0, 8'h00);
        cycle(0, 0, 8'h00);
        cycle(0, 1, A_LOW);
        #1;
        check_eq("t1_low_word", {16'h0, db_out_CR}, 32'h0000_FFF1);
        check_eq("t1_hold_on", {31'h0, hold_active}, 32'h1);
        repeat (49) cycle(0, 0, 8'h00);
        cycle(0, 1, A_HIGH);
        #1;
        check_eq("t1_high_word", {16'h0, db_out_CR}, 32'h0000_0001);
        check_eq("t1_hold_off", {31'h0, hold_active}, 32'h0);

        // Timeout after exactly T edges
        cycle(0, 0, 8'h00);
        cycle(0, 1, A_LOW);
        #1;
        k = 0;
        while (hold_active && k < T + 10) begin
            cycle(0, 0, 8'h00);
            #1;
            k++;
        end
        check_eq("t2_timeout_len", 32'(k), 32'(T));
        cycle(0, 1, A_STAT);
        #1;
        check_eq("t2_status", {16'h0, db_out_CR}, 32'h0000_0001);
        cycle(0, 0, 8'h00);
        cycle(0, 1, A_HIGH);
        cycle(0, 0, 8'h00);

        // Write abort
        cycle(0, 1, A_LOW);
        repeat (3) cycle(0, 0, 8'h00);
        cycle(1, 0, 8'h05);
        #1;
        check_eq("t3_abort_hold", {31'h0, hold_active}, 32'h0);
        cycle(0, 0, 8'h00);
        cycle(0, 1, A_STAT);
        #1;
        check_eq("t3_status", {16'h0, db_out_CR}, 32'h0000_0002);
        cycle(0, 0, 8'h00);
        cycle(0, 1, A_LOW);
        repeat (5) cycle(0, 0, 8'h00);
        cycle(0, 1, A_HIGH);
        cycle(0, 0, 8'h00);

        // Long strobe: one LOW action, no reload
        repeat (10) cycle(0, 1, A_LOW);
        #1;
        k = 0;
        while (hold_active && k < T + 10) begin
            cycle(0, 0, 8'h00);
            #1;
            k++;
        end
        check_eq("t4_no_reload", 32'(k), 32'(T - 9));

        // HIGH read on the timeout edge wins over the timeout
        prev_ab = m_abandon;
        cycle(0, 1, A_LOW);
        repeat (T - 1) cycle(0, 0, 8'h00);
        cycle(0, 1, A_HIGH);
        #1;
        check_eq("t5_hold_off", {31'h0, hold_active}, 32'h0);
        cycle(0, 0, 8'h00);
        cycle(0, 1, A_STAT);
        #1;
        check_eq("t5_no_abandon", {16'h0, db_out_CR}, 32'(prev_ab));

        // Saturation, then clear
        repeat (300) begin
            cycle(0, 0, 8'h00);
            cycle(0, 1, A_LOW);
            cycle(1, 0, 8'h05);
            cycle(0, 0, 8'h00);
        end
        cycle(0, 1, A_STAT);
        #1;
        check_eq("t5_saturate", {16'h0, db_out_CR}, 32'h0000_00FF);
        cycle(1, 0, A_CLR);
        cycle(0, 0, 8'h00);
        cycle(0, 1, A_STAT);
        #1;
        check_eq("t5_clear", {16'h0, db_out_CR}, 32'h0000_0000);

        // Async reset mid-hold
        cycle(0, 0, 8'h00);
        cycle(0, 1, A_LOW);
        cycle(0, 0, 8'h00);
        cycle(0, 1, A_STAT);
        #3 reset = 1'b0;
        #1;
        check_eq("t6_rst_db", {16'h0, db_out_CR}, 32'h0);
        check_eq("t6_rst_avail", {31'h0, data_from_CR_avail}, 32'h0);
        check_eq("t6_rst_hold", {31'h0, hold_active}, 32'h0);
        rq = 1'b0; wq = 1'b0;
        model_reset();
        @(posedge xclk);
        #2 reset = 1'b1;
        cycle(0, 1, 8'h7F);
        #1;
        check_eq("t6_undec_db", {16'h0, db_out_CR}, 32'h0000_FFFF);
        check_eq("t6_undec_avail", {31'h0, data_from_CR_avail}, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic nr, nw;
            logic [7:0] na;
            nr = ($urandom_range(0, 2) == 0) ? ~rq : rq;
            nw = ($urandom_range(0, 15) == 0) ? ~wq : wq;
            na = ($urandom_range(0, 3) == 0) ? addr_tab[$urandom_range(0, 5)] : ab;
            count_step = ($urandom_range(0, 7) == 0) ? int'($urandom) : 1;
            cycle(nw, nr, na);
        end
        count_step = 1;
        cycle(0, 0, 8'h00);
        cycle(0, 0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
